// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-unit states, step numbers,
// instruction classes and the bundle of datapath control strobes.
package cpu_pkg;

    typedef logic [4:0] opcode_t;
    typedef logic [2:0] step_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_XOR  = 5'b01011;
    localparam opcode_t OP_SHL  = 5'b01100;
    localparam opcode_t OP_ADDI = 5'b01101;
    localparam opcode_t OP_ANDI = 5'b01110;
    localparam opcode_t OP_ORI  = 5'b01111;
    localparam opcode_t OP_MUL  = 5'b10000;
    localparam opcode_t OP_DIV  = 5'b10001;
    localparam opcode_t OP_NEG  = 5'b10010;
    localparam opcode_t OP_NOT  = 5'b10011;
    localparam opcode_t OP_BRX  = 5'b10100;
    localparam opcode_t OP_JR   = 5'b10101;
    localparam opcode_t OP_IN   = 5'b10111;
    localparam opcode_t OP_OUT  = 5'b11000;
    localparam opcode_t OP_MFHI = 5'b11001;
    localparam opcode_t OP_MFLO = 5'b11010;
    localparam opcode_t OP_NOP  = 5'b11011;
    localparam opcode_t OP_HALT = 5'b11100;

    localparam step_t T0 = 3'd0;
    localparam step_t T1 = 3'd1;
    localparam step_t T2 = 3'd2;
    localparam step_t T3 = 3'd3;
    localparam step_t T4 = 3'd4;
    localparam step_t T5 = 3'd5;
    localparam step_t T6 = 3'd6;
    localparam step_t T7 = 3'd7;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_UNARY,
        CL_BRX, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT, CL_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       ba_out;
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       y_in;
        logic       z_in;
        logic       zhigh_out;
        logic       zlow_out;
        logic       hi_in;
        logic       hi_out;
        logic       lo_in;
        logic       lo_out;
        logic       c_out;
        logic       inport_out;
        logic       outport_in;
        logic       con_in;
        logic       read;
        logic       ram_write;
        logic [4:0] alu_op;
    } ctrl_t;

    // Immediate forms reuse the ALU code of their register counterpart.
    function automatic opcode_t imm_alu_op(input opcode_t op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: instruction class and the step on which
// that class finishes executing.
module cu_decode
    import cpu_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t iclass,
    output step_t        last_step
);

    always_comb begin
        iclass = CL_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_XOR, OP_SHL: iclass = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:                iclass = CL_IMM;
            OP_LDI:                                  iclass = CL_LDI;
            OP_LD:                                   iclass = CL_LD;
            OP_ST:                                   iclass = CL_ST;
            OP_MUL, OP_DIV:                          iclass = CL_MULDIV;
            OP_NEG, OP_NOT:                          iclass = CL_UNARY;
            OP_BRX:                                  iclass = CL_BRX;
            OP_JR:                                   iclass = CL_JR;
            OP_IN:                                   iclass = CL_IN;
            OP_OUT:                                  iclass = CL_OUT;
            OP_MFHI:                                 iclass = CL_MFHI;
            OP_MFLO:                                 iclass = CL_MFLO;
            OP_NOP:                                  iclass = CL_NOP;
            OP_HALT:                                 iclass = CL_HALT;
            default:                                 iclass = CL_ILLEGAL;
        endcase
    end

    always_comb begin
        last_step = T2;
        case (iclass)
            CL_LD, CL_ST:                                last_step = T7;
            CL_MULDIV, CL_BRX:                           last_step = T6;
            CL_ALU, CL_IMM, CL_LDI:                      last_step = T5;
            CL_UNARY:                                    last_step = T4;
            CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO:      last_step = T3;
            default:                                     last_step = T2;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Control unit: Moore sequencer driving datapath strobes from {state, step, opcode}.
// Define CU_ILLEGAL_TRAP_EN to halt on unassigned opcodes instead of treating them as nop.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        Out_portIn,
    output logic        CONin,
    output logic        read,
    output logic        RAMwrite,
    output logic [4:0]  alu_op,
    output logic        run_led
);

    state_t       state;
    step_t        step;
    opcode_t      opcode;
    instr_class_t dec_class;
    instr_class_t iclass;
    step_t        last_step;
    ctrl_t        ctrl;
    logic         unused_ir_fields;

    assign opcode           = ir[31:27];
    assign unused_ir_fields = ^ir[26:0];

    cu_decode u_decode (
        .opcode    (opcode),
        .iclass    (dec_class),
        .last_step (last_step)
    );

    always_comb begin
        iclass = dec_class;
        if (dec_class == CL_ILLEGAL) begin
`ifdef CU_ILLEGAL_TRAP_EN
            iclass = CL_HALT;
`else
            iclass = CL_NOP;
`endif
        end
    end

    // stop is only consulted on an instruction's final step, so a halt request never truncates one.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= S_RESET;
            step    <= T0;
            run_led <= 1'b0;
        end else begin
            case (state)
                S_RESET, S_HALT: begin
                    if (run) begin
                        state   <= S_FETCH;
                        step    <= T0;
                        run_led <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (step != T2) begin
                        step <= step + 3'd1;
                    end else if (iclass == CL_HALT) begin
                        state   <= S_HALT;
                        step    <= T0;
                        run_led <= 1'b0;
                    end else if (iclass == CL_NOP) begin
                        state   <= stop ? S_HALT : S_FETCH;
                        step    <= T0;
                        run_led <= !stop;
                    end else begin
                        state <= S_EXEC;
                        step  <= T3;
                    end
                end
                S_EXEC: begin
                    if (step == last_step) begin
                        state   <= stop ? S_HALT : S_FETCH;
                        step    <= T0;
                        run_led <= !stop;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    state   <= S_RESET;
                    step    <= T0;
                    run_led <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                case (step)
                    T0:      begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
                    T1:      begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                    T2:      begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    CL_ALU, CL_IMM: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.z_in = 1'b1;
                                if (iclass == CL_ALU) begin
                                    ctrl.grc    = 1'b1;
                                    ctrl.rout   = 1'b1;
                                    ctrl.alu_op = opcode;
                                end else begin
                                    ctrl.c_out  = 1'b1;
                                    ctrl.alu_op = imm_alu_op(opcode);
                                end
                            end
                            T5:      begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = OP_ADD; end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                if (iclass == CL_LDI) begin
                                    ctrl.gra = 1'b1;
                                    ctrl.rin = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                ctrl.mdr_in = 1'b1;
                                if (iclass == CL_LD) begin
                                    ctrl.read = 1'b1;
                                end else begin
                                    ctrl.gra  = 1'b1;
                                    ctrl.rout = 1'b1;
                                end
                            end
                            T7: begin
                                if (iclass == CL_LD) begin
                                    ctrl.mdr_out = 1'b1;
                                    ctrl.gra     = 1'b1;
                                    ctrl.rin     = 1'b1;
                                end else begin
                                    ctrl.ram_write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    CL_MULDIV: begin
                        case (step)
                            T3:      begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4:      begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode; end
                            T5:      begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                            T6:      begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_UNARY: begin
                        case (step)
                            T3:      begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = opcode; end
                            T4:      begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_BRX: begin
                        case (step)
                            T3:      begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1; end
                            T4:      begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                            T5:      begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = OP_ADD; end
                            T6:      begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con; end
                            default: ;
                        endcase
                    end
                    CL_JR:   if (step == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                    CL_IN:   if (step == T3) begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_OUT:  if (step == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outport_in = 1'b1; end
                    CL_MFHI: if (step == T3) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_MFLO: if (step == T3) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign Rin        = ctrl.rin;
    assign Rout       = ctrl.rout;
    assign BAout      = ctrl.ba_out;
    assign PCout      = ctrl.pc_out;
    assign PCin       = ctrl.pc_in;
    assign IncPC      = ctrl.inc_pc;
    assign IRin       = ctrl.ir_in;
    assign MARin      = ctrl.mar_in;
    assign MDRin      = ctrl.mdr_in;
    assign MDRout     = ctrl.mdr_out;
    assign Yin        = ctrl.y_in;
    assign Zin        = ctrl.z_in;
    assign Zhighout   = ctrl.zhigh_out;
    assign Zlowout    = ctrl.zlow_out;
    assign HIin       = ctrl.hi_in;
    assign HIout      = ctrl.hi_out;
    assign LOin       = ctrl.lo_in;
    assign LOout      = ctrl.lo_out;
    assign Cout       = ctrl.c_out;
    assign InPortout  = ctrl.inport_out;
    assign Out_portIn = ctrl.outport_in;
    assign CONin      = ctrl.con_in;
    assign read       = ctrl.read;
    assign RAMwrite   = ctrl.ram_write;
    assign alu_op     = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: fetch, execute sequences, branch gating,
// halt/stop handling and synchronous clear, all against hand-derived strobe patterns.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, run, stop, con;
    logic [31:0] ir;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
    logic Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout;
    logic InPortout, Out_portIn, CONin, read, RAMwrite, run_led;
    logic [4:0] alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    control_unit dut (
        .clock(clock), .clear(clear), .run(run), .stop(stop), .ir(ir), .con(con),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Cout(Cout), .InPortout(InPortout), .Out_portIn(Out_portIn), .CONin(CONin),
        .read(read), .RAMwrite(RAMwrite), .alu_op(alu_op), .run_led(run_led)
    );

    wire [31:0] obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin,
                       MDRin, MDRout, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
                       Cout, InPortout, Out_portIn, CONin, read, RAMwrite, alu_op};

    localparam logic [31:0] GRA = 32'h8000_0000, GRB = 32'h4000_0000, GRC = 32'h2000_0000;
    localparam logic [31:0] RIN = 32'h1000_0000, ROUT = 32'h0800_0000, BAOUT = 32'h0400_0000;
    localparam logic [31:0] PCOUT = 32'h0200_0000, PCIN = 32'h0100_0000, INCPC = 32'h0080_0000;
    localparam logic [31:0] IRIN = 32'h0040_0000, MARIN = 32'h0020_0000, MDRIN = 32'h0010_0000;
    localparam logic [31:0] MDROUT = 32'h0008_0000, YIN = 32'h0004_0000, ZIN = 32'h0002_0000;
    localparam logic [31:0] ZHIGH = 32'h0001_0000, ZLOW = 32'h0000_8000, HIIN = 32'h0000_4000;
    localparam logic [31:0] LOIN = 32'h0000_1000, COUT = 32'h0000_0400, READ = 32'h0000_0040;
    localparam logic [31:0] CONIN = 32'h0000_0080, RAMW = 32'h0000_0020;
    localparam logic [31:0] A_ADD = 32'd3, A_AND = 32'd5, A_MUL = 32'd16, A_NEG = 32'd18;
    localparam logic [31:0] F0 = PCOUT | MARIN | INCPC;
    localparam logic [31:0] F1 = READ | MDRIN;
    localparam logic [31:0] F2 = MDROUT | IRIN;

    task automatic test_reset();
        clear = 1'b1; run = 1'b0; stop = 1'b0; con = 1'b0; ir = 32'h0;
        @(negedge clock); @(negedge clock); #1;
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL reset_idle: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        run = 1'b1;
        @(negedge clock); #1;
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL reset_clear_wins: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        clear = 1'b0; run = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL reset_wait_run: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        run = 1'b1;
        @(negedge clock); #1;
        run = 1'b0;
        checks++;
        if ({run_led, obs} !== {1'b1, F0}) begin
            errors++; $display("FAIL reset_to_fetch: got run_led=%b outputs=%h, expected 1/%h", run_led, obs, F0);
        end
    endtask

    task automatic test_execute();
        logic [31:0] irs [8];
        int          len [8];
        logic [31:0] exp [8][9];
        irs[0] = 32'h1891_8000; len[0] = 7;
        exp[0] = '{F0, F1, F2, GRB|ROUT|YIN, GRC|ROUT|ZIN|A_ADD, ZLOW|GRA|RIN, F0, 0, 0};
        irs[1] = 32'h0080_0004; len[1] = 9;
        exp[1] = '{F0, F1, F2, GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOW|MARIN, READ|MDRIN, MDROUT|GRA|RIN, F0};
        irs[2] = 32'h7088_0005; len[2] = 7;
        exp[2] = '{F0, F1, F2, GRB|ROUT|YIN, COUT|ZIN|A_AND, ZLOW|GRA|RIN, F0, 0, 0};
        irs[3] = 32'h8100_0000; len[3] = 8;
        exp[3] = '{F0, F1, F2, GRA|ROUT|YIN, GRB|ROUT|ZIN|A_MUL, ZLOW|LOIN, ZHIGH|HIIN, F0, 0};
        irs[4] = 32'h9080_0000; len[4] = 6;
        exp[4] = '{F0, F1, F2, GRB|ROUT|ZIN|A_NEG, ZLOW|GRA|RIN, F0, 0, 0, 0};
        irs[5] = 32'h0880_0010; len[5] = 7;
        exp[5] = '{F0, F1, F2, GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOW|GRA|RIN, F0, 0, 0};
        irs[6] = 32'h1080_0000; len[6] = 9;
        exp[6] = '{F0, F1, F2, GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOW|MARIN, GRA|ROUT|MDRIN, RAMW, F0};
        irs[7] = 32'hA880_0000; len[7] = 5;
        exp[7] = '{F0, F1, F2, GRA|ROUT|PCIN, F0, 0, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            ir = irs[k];
            for (int i = 0; i < len[k]; i++) begin
                #1;
                checks++;
                if (obs !== exp[k][i]) begin
                    errors++; $display("FAIL exec[%0d] ir=%h step %0d: got %h, expected %h", k, irs[k], i, obs, exp[k][i]);
                end
                if (i < len[k] - 1) @(negedge clock);
            end
        end
    endtask

    task automatic test_brx();
        logic [31:0] exp [8];
        logic        final_con;
        for (int pass = 0; pass < 2; pass++) begin
            final_con = (pass == 0);
            ir  = 32'hA080_0000;
            exp = '{F0, F1, F2, GRA|ROUT|CONIN, PCOUT|YIN, COUT|ZIN|A_ADD,
                    ZLOW | (final_con ? PCIN : 32'h0), F0};
            for (int i = 0; i < 8; i++) begin
                con = (i >= 3 && i <= 5) ? ~final_con : final_con;
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    errors++; $display("FAIL brx con=%b step %0d: got %h, expected %h", final_con, i, obs, exp[i]);
                end
                if (i < 7) @(negedge clock);
            end
        end
        con = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] irs [3];
        logic [31:0] exp [10];
        irs = '{32'hD800_0000, 32'hD800_0000, 32'hE800_0000};
`ifdef CU_ILLEGAL_TRAP_EN
        exp = '{F0, F1, F2, F0, F1, F2, F0, F1, F2, 32'h0};
`else
        exp = '{F0, F1, F2, F0, F1, F2, F0, F1, F2, F0};
`endif
        for (int i = 0; i < 10; i++) begin
            if (i < 9) ir = irs[i / 3];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL nop_chain step %0d: got %h, expected %h", i, obs, exp[i]);
            end
            if (i < 9) @(negedge clock);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        run = 1'b1;
        @(negedge clock); #1;
        run = 1'b0;
        checks++;
        if (obs !== F0) begin
            errors++; $display("FAIL illegal_resume: got %h, expected %h", obs, F0);
        end
`endif
    endtask

    task automatic test_stop();
        logic [31:0] exp [6];
        exp = '{F0, F1, F2, GRB|ROUT|YIN, GRC|ROUT|ZIN|A_ADD, ZLOW|GRA|RIN};
        ir = 32'h1891_8000;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) stop = 1'b1;
            #1;
            checks++;
            if ({run_led, obs} !== {1'b1, exp[i]}) begin
                errors++; $display("FAIL stop_midway step %0d: got %b/%h, expected 1/%h", i, run_led, obs, exp[i]);
            end
            @(negedge clock);
        end
        #1;
        stop = 1'b0;
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL stop_halted: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        run = 1'b1;
        @(negedge clock); #1;
        run = 1'b0;
        checks++;
        if ({run_led, obs} !== {1'b1, F0}) begin
            errors++; $display("FAIL stop_resume: got %b/%h, expected 1/%h", run_led, obs, F0);
        end
    endtask

    task automatic test_halt();
        logic [31:0] exp [3];
        exp = '{F0, F1, F2};
        ir = 32'hE000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL halt_fetch step %0d: got %h, expected %h", i, obs, exp[i]);
            end
            @(negedge clock);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({run_led, obs} !== 33'h0) begin
                errors++; $display("FAIL halted cycle %0d: got run_led=%b outputs=%h, expected all zero", c, run_led, obs);
            end
            if (c < 4) @(negedge clock);
        end
        run = 1'b1;
        ir  = 32'h1891_8000;
        @(negedge clock); #1;
        run = 1'b0;
        checks++;
        if ({run_led, obs} !== {1'b1, F0}) begin
            errors++; $display("FAIL halt_resume: got %b/%h, expected 1/%h", run_led, obs, F0);
        end
    endtask

    task automatic test_clear_mid_st();
        logic [31:0] exp [7];
        exp = '{F0, F1, F2, GRB|BAOUT|YIN, COUT|ZIN|A_ADD, ZLOW|MARIN, GRA|ROUT|MDRIN};
        ir = 32'h1080_0000;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL st_before_clear step %0d: got %h, expected %h", i, obs, exp[i]);
            end
            if (i < 6) @(negedge clock);
        end
        clear = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (RAMwrite !== 1'b0) begin
            errors++; $display("FAIL clear_ramwrite: got %b, expected 0", RAMwrite);
        end
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL clear_mid_st: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        clear = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({run_led, obs} !== 33'h0) begin
            errors++; $display("FAIL clear_stays_reset: got run_led=%b outputs=%h, expected all zero", run_led, obs);
        end
        run = 1'b1;
        @(negedge clock); #1;
        run = 1'b0;
        checks++;
        if ({run_led, obs} !== {1'b1, F0}) begin
            errors++; $display("FAIL clear_restart: got %b/%h, expected 1/%h", run_led, obs, F0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_execute();
        test_brx();
        test_back_to_back();
        test_stop();
        test_halt();
        test_clear_mid_st();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clock and clear.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  datapath clock; all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  start/resume fetching.
- stop  in  1  halt request, sampled at instruction boundary.
- ir  in  32  IR contents; opcode = ir[31:27].
- con  in  1  branch-condition flag from con_ff.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select controls.
- PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout  out  1 each  datapath strobes.
- Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout  out  1 each  datapath strobes.
- InPortout, Out_portIn, CONin  out  1 each  I/O and condition-latch strobes.
- read, RAMwrite  out  1 each  memory controls.
- alu_op  out  5  ALU opcode.
- run_led  out  1  high when not HALT.

Function
REQ-003 SHALL implement the states S_RESET, S_FETCH, S_EXEC and S_HALT, plus a 3-bit step counter T (0..7).
REQ-004 Outputs SHALL be Moore, decoded from {state, T, opcode}; each strobe SHALL be high for exactly its listed step; all unlisted outputs SHALL be 0.
REQ-005 Fetch SHALL run as follows:
- T0: PCout, MARin, IncPC.
- T1: read, MDRin.
- T2: MDRout, IRin.
- S_EXEC SHALL begin at T3 the cycle after T2.
REQ-006 Each execute sequence SHALL be:
- R-ALU (add..shl, 00011-01100): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin.
- Immediate (addi/andi/ori): T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
- ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
- ld: T3–T4 as for ldi; T5 Zlowout MARin; T6 read MDRin; T7 MDRout Gra Rin.
- st: T3–T5 as for ld; T6 Gra Rout MDRin (read=0); T7 RAMwrite.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin.
- neg/not: T3 Grb Rout Zin; T4 Zlowout Gra Rin.
- brx: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout PCin only if con=1.
- jr: T3 Gra Rout PCin.
- in: T3 InPortout Gra Rin.
- out: T3 Gra Rout Out_portIn.
- mfhi/mflo: T3 HIout (or LOout) Gra Rin.
- nop: no execute step.
REQ-007 alu_op SHALL equal the IR opcode for R-ALU, mul, div, neg and not; it SHALL be ADD during ld/ldi/st/brx address steps and the add/and/or code for addi/andi/ori; it SHALL be 0 otherwise.
REQ-008 After the final step of any instruction, the next cycle SHALL be S_FETCH T0; nop SHALL return to T0 directly after T2.
REQ-009 halt (11100) SHALL enter S_HALT after T2; S_HALT SHALL drive all outputs 0 and exit to S_FETCH T0 only on run=1.
REQ-010 stop=1 SHALL be sampled only at the final step and SHALL enter S_HALT instead of S_FETCH; stop asserted mid-instruction SHALL NOT abort the instruction.
REQ-011 A con change during T3–T5 of brx SHALL be ignored; only the value at T6 SHALL gate PCin.
REQ-012 The step counter SHALL never wrap; reaching T7 without completion is impossible by construction.

Reset
REQ-013 clear=1 at any edge SHALL force S_RESET and T=0, with all outputs 0, run_led=0 and alu_op=0.
REQ-014 This SHALL hold even mid-instruction; any in-flight memory write SHALL be abandoned.
REQ-015 S_RESET SHALL move to S_FETCH T0 on the first edge with clear=0 and run=1, and SHALL stay in S_RESET otherwise.

Configuration
REQ-016 With CU_ILLEGAL_TRAP_EN defined, an unassigned opcode SHALL enter S_HALT after T2; without it, an unassigned opcode SHALL execute as nop.

Structure
REQ-017 Opcode constants, state encoding and step constants SHALL live in the shared package cpu_pkg.
REQ-018 One sub-module, cu_decode (combinational opcode-to-instruction-class decode), SHALL be instantiated.

Verification
REQ-019 Reset then run=1: T0 with PCout=MARin=IncPC=1; T2 IRin=1; outputs all 0 during clear.
REQ-020 add (ir=0x18918000): T3 Grb Rout Yin; T4 Grc Rout Zin with alu_op=00011; T5 Zlowout Gra Rin; the next cycle is T0.
REQ-021 ld: read=1 at T1 and T6; MARin at T5; alu_op=ADD at T4; 8 cycles per instruction.
REQ-022 brx: con=1 gives PCin at T6; con=0 gives PCin=0 at T6; both return to T0.
REQ-023 halt, then run=1 after 5 cycles: run_led=0 while halted, and fetch resumes at T0.
REQ-024 clear=1 at st T6: RAMwrite stays 0 and the state is S_RESET the next cycle.
